prog_loader: RTL

//  Byte-stream program loader sitting directly upstream of the CPU core's instruction port.
//  - Assembles a host byte stream (header + 32-bit words) into instruction words.
//  - Presents each word to the core on MEM_INST / MEM_INST_ENB with a word index.
//  - Holds the core in reset (CPU_RST) until the whole image is loaded.

---
 rtl/prog_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader in front of the core's instruction port.
// Assembles a host byte stream (16-bit word count, then 32-bit words, all MSB first) into
// instruction words. Each word is presented to the core with its 0-based index. The core is
// held in reset until the whole image has been loaded.
//
// Ports:
//   CLK, RST      clock (rising edge) and asynchronous active-high reset
//   START         1-cycle pulse that begins a new load (honoured in IDLE/DONE/ERR only)
//   BYTE_IN       host data byte, transferred when BYTE_VALID && BYTE_READY
//   BYTE_VALID    BYTE_IN valid
//   BYTE_READY    loader accepts a byte this cycle (HDR_HI/HDR_LO/DATA)
//   MEM_INST      assembled instruction word
//   MEM_INST_ENB  1-cycle write strobe for MEM_INST
//   INST_ADDR     word index of MEM_INST
//   CPU_RST       core reset, high until the image is loaded
//   BUSY          load in progress
//   DONE          image loaded, core released
//   ERROR         header count exceeded MAX_WORDS
module prog_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic [31:0] MEM_INST,
  output logic        MEM_INST_ENB,
  output logic [15:0] INST_ADDR,
  output logic        CPU_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StDone,
    StErr
  } state_e;

  state_e      state_q;
  logic [7:0]  hdr_hi_q;
  logic [15:0] word_total_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;      // first three bytes of the word being assembled

  logic        byte_xfer;
  logic [15:0] hdr_count;
  logic        can_start;

  assign BYTE_READY = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
  assign BUSY       = BYTE_READY;
  assign byte_xfer  = BYTE_VALID && BYTE_READY;
  assign hdr_count  = {hdr_hi_q, BYTE_IN};
  assign can_start  = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      hdr_hi_q     <= '0;
      word_total_q <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      MEM_INST     <= '0;
      MEM_INST_ENB <= 1'b0;
      INST_ADDR    <= '0;
      CPU_RST      <= 1'b1;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse unless re-armed below.
      MEM_INST_ENB <= 1'b0;

      if (can_start && START) begin
        state_q    <= StHdrHi;
        word_cnt_q <= '0;
        byte_cnt_q <= '0;
        CPU_RST    <= 1'b1;
        DONE       <= 1'b0;
        ERROR      <= 1'b0;
      end else if (byte_xfer) begin
        unique case (state_q)
          StHdrHi: begin
            hdr_hi_q <= BYTE_IN;
            state_q  <= StHdrLo;
          end
          StHdrLo: begin
            word_total_q <= hdr_count;
            if (hdr_count == 16'd0) begin
              state_q <= StDone;
              DONE    <= 1'b1;
              CPU_RST <= 1'b0;
            end else if ({1'b0, hdr_count} > MaxWords) begin
              state_q <= StErr;
              ERROR   <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
          StData: begin
            if (byte_cnt_q == 2'd3) begin
              MEM_INST     <= {asm_q, BYTE_IN};
              INST_ADDR    <= word_cnt_q;
              MEM_INST_ENB <= 1'b1;
              word_cnt_q   <= word_cnt_q + 16'd1;
              byte_cnt_q   <= '0;
              if (word_cnt_q == word_total_q - 16'd1) begin
                state_q <= StDone;
                DONE    <= 1'b1;
                CPU_RST <= 1'b0;
              end
            end else begin
              asm_q      <= {asm_q[15:0], BYTE_IN};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
